// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and extension helper for the RV32I load/store unit.
// Defining LSU_MISALIGNED_TRAP_EN makes misaligned half/word accesses fault instead of being force-aligned.
package lsu_pkg;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  localparam logic [3:0] SEL_NONE    = 4'b0000;
  localparam logic [3:0] SEL_BYTE0   = 4'b0001;
  localparam logic [3:0] SEL_HALF_LO = 4'b0011;
  localparam logic [3:0] SEL_HALF_HI = 4'b1100;
  localparam logic [3:0] SEL_WORD    = 4'b1111;

`ifdef LSU_MISALIGNED_TRAP_EN
  localparam bit MISALIGNED_TRAP_EN = 1'b1;
`else
  localparam bit MISALIGNED_TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    LSU_IDLE    = 2'b00,
    LSU_BUS     = 2'b01,
    LSU_BACKOFF = 2'b10,
    LSU_DONE    = 2'b11
  } lsu_state_e;

  // Byte or half extension to 32 bits; sign_en selects sign fill over zero fill.
  function automatic logic [31:0] lsu_extend(input logic [15:0] val,
                                             input logic        is_half,
                                             input logic        sign_en);
    logic [31:0] res;
    if (is_half) begin
      res = {{16{sign_en & val[15]}}, val};
    end else begin
      res = {{24{sign_en & val[7]}}, val[7:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store lanes/data, load extraction/extension and access legality.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic        store_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] dat_i,
  output logic [3:0]  sel_o,
  output logic [31:0] sdata_o,
  output logic [31:0] ldata_o,
  output logic        illegal_o,
  output logic        misaligned_o
);

  logic [7:0]  ld_byte_s;
  logic [15:0] ld_half_s;

  assign ld_byte_s = dat_i[{addr_lo_i, 3'b000} +: 8];
  assign ld_half_s = dat_i[{addr_lo_i[1], 4'b0000} +: 16];

  // Lane select, replication and extension per access size; half/word ignore low address bits.
  always_comb begin
    sel_o        = SEL_NONE;
    sdata_o      = 32'h0000_0000;
    ldata_o      = 32'h0000_0000;
    illegal_o    = 1'b0;
    misaligned_o = 1'b0;
    case (funct3_i)
      FUNCT3_LB: begin
        sel_o   = SEL_BYTE0 << addr_lo_i;
        sdata_o = {4{wdata_i[7:0]}};
        ldata_o = lsu_extend({8'h00, ld_byte_s}, 1'b0, 1'b1);
      end
      FUNCT3_LH: begin
        sel_o        = addr_lo_i[1] ? SEL_HALF_HI : SEL_HALF_LO;
        sdata_o      = {2{wdata_i[15:0]}};
        ldata_o      = lsu_extend(ld_half_s, 1'b1, 1'b1);
        misaligned_o = MISALIGNED_TRAP_EN & addr_lo_i[0];
      end
      FUNCT3_LW: begin
        sel_o        = SEL_WORD;
        sdata_o      = wdata_i;
        ldata_o      = dat_i;
        misaligned_o = MISALIGNED_TRAP_EN & (addr_lo_i != 2'b00);
      end
      FUNCT3_LBU: begin
        sel_o     = SEL_BYTE0 << addr_lo_i;
        ldata_o   = lsu_extend({8'h00, ld_byte_s}, 1'b0, 1'b0);
        illegal_o = store_i;
      end
      FUNCT3_LHU: begin
        sel_o        = addr_lo_i[1] ? SEL_HALF_HI : SEL_HALF_LO;
        ldata_o      = lsu_extend(ld_half_s, 1'b1, 1'b0);
        illegal_o    = store_i;
        misaligned_o = MISALIGNED_TRAP_EN & addr_lo_i[0];
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Wishbone B4 classic initiator executing one RV32I load/store per request, with rty_i retry and fault reporting.
// Optional LSU_MISALIGNED_TRAP_EN turns misaligned half/word accesses into faults without a bus cycle.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MAX_RETRIES = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        fault_o,
  output logic [31:0] rdata_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [31:0] adr_o,
  output logic [3:0]  sel_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  input  logic        err_i,
  input  logic        rty_i
);

  localparam int unsigned RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);

  lsu_state_e    state_q, state_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [1:0]    addr_lo_q, addr_lo_d;
  logic          we_q, we_d;
  logic          cyc_q, cyc_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          fault_q, fault_d;
  logic [31:0]   adr_q, adr_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   dat_q, dat_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          accept_s;
  logic [2:0]    al_funct3_s;
  logic          al_store_s;
  logic [1:0]    al_addr_lo_s;
  logic [3:0]    al_sel_s;
  logic [31:0]   al_sdata_s;
  logic [31:0]   al_ldata_s;
  logic          al_illegal_s;
  logic          al_misaligned_s;

  // The aligner sees the incoming request while one can be accepted, the captured access otherwise.
  assign accept_s     = (state_q == LSU_IDLE) || (state_q == LSU_DONE);
  assign al_funct3_s  = accept_s ? funct3_i : funct3_q;
  assign al_store_s   = accept_s ? store_i : we_q;
  assign al_addr_lo_s = accept_s ? addr_i[1:0] : addr_lo_q;

  lsu_lane_align u_lane_align (
    .funct3_i     (al_funct3_s),
    .store_i      (al_store_s),
    .addr_lo_i    (al_addr_lo_s),
    .wdata_i      (wdata_i),
    .dat_i        (dat_i),
    .sel_o        (al_sel_s),
    .sdata_o      (al_sdata_s),
    .ldata_o      (al_ldata_s),
    .illegal_o    (al_illegal_s),
    .misaligned_o (al_misaligned_s)
  );

  // Next-state and next-output logic; DONE accepts a new request just like IDLE.
  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    funct3_d  = funct3_q;
    addr_lo_d = addr_lo_q;
    we_d      = we_q;
    cyc_d     = cyc_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    fault_d   = fault_q;
    adr_d     = adr_q;
    sel_d     = sel_q;
    dat_d     = dat_q;
    rdata_d   = rdata_q;
    case (state_q)
      LSU_IDLE, LSU_DONE: begin
        retry_d = {RW{1'b0}};
        cyc_d   = 1'b0;
        busy_d  = 1'b0;
        if (req_i) begin
          funct3_d  = funct3_i;
          addr_lo_d = addr_i[1:0];
          we_d      = store_i;
          adr_d     = {addr_i[31:2], 2'b00};
          sel_d     = al_sel_s;
          dat_d     = al_sdata_s;
          if (al_illegal_s || al_misaligned_s) begin
            state_d = LSU_DONE;
            done_d  = 1'b1;
            fault_d = 1'b1;
          end else begin
            state_d = LSU_BUS;
            cyc_d   = 1'b1;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = LSU_IDLE;
        end
      end
      LSU_BUS: begin
        if (ack_i) begin
          state_d = LSU_DONE;
          cyc_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          fault_d = 1'b0;
          if (!we_q) begin
            rdata_d = al_ldata_s;
          end else begin
            rdata_d = rdata_q;
          end
        end else if (err_i) begin
          state_d = LSU_DONE;
          cyc_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          fault_d = 1'b1;
        end else if (rty_i) begin
          cyc_d = 1'b0;
          if (retry_q < RETRY_LIMIT) begin
            retry_d = retry_q + RW'(1);
            state_d = LSU_BACKOFF;
          end else begin
            state_d = LSU_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            fault_d = 1'b1;
          end
        end else begin
          state_d = LSU_BUS;
        end
      end
      LSU_BACKOFF: begin
        state_d = LSU_BUS;
        cyc_d   = 1'b1;
      end
      default: begin
        state_d = LSU_IDLE;
        cyc_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any bus cycle without a completion pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= LSU_IDLE;
      retry_q   <= {RW{1'b0}};
      funct3_q  <= 3'b000;
      addr_lo_q <= 2'b00;
      we_q      <= 1'b0;
      cyc_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
      adr_q     <= 32'h0000_0000;
      sel_q     <= 4'b0000;
      dat_q     <= 32'h0000_0000;
      rdata_q   <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      retry_q   <= retry_d;
      funct3_q  <= funct3_d;
      addr_lo_q <= addr_lo_d;
      we_q      <= we_d;
      cyc_q     <= cyc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fault_q   <= fault_d;
      adr_q     <= adr_d;
      sel_q     <= sel_d;
      dat_q     <= dat_d;
      rdata_q   <= rdata_d;
    end
  end

  assign cyc_o   = cyc_q;
  assign stb_o   = cyc_q;
  assign we_o    = we_q;
  assign adr_o   = adr_q;
  assign sel_o   = sel_q;
  assign dat_o   = dat_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign fault_o = fault_q;
  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: scripted Wishbone responder plus an expected-result queue.
module tb_load_store_unit;

  localparam int BUDGET = 40;

  typedef struct {
    string       name;
    logic        store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_init;
    int          waits;
    int          n_rty;
    bit          err;
    logic        fault;
    logic [31:0] rdata;
    bit          chk_rdata;
    int          lat;
    bit          cyc;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    int          drops;
    logic [31:0] mem_after;
  } vec_t;

  typedef struct {
    bit          done;
    logic        fault;
    logic [31:0] rdata;
    int          lat;
    bit          cyc_seen;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        we;
    logic        busy1;
    bit          unstable;
    bit          stb_bad;
    int          drops;
    logic [31:0] mem;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0;
  logic        store_i = 1'b0;
  logic [2:0]  funct3_i = 3'b000;
  logic [31:0] addr_i = 32'h0;
  logic [31:0] wdata_i = 32'h0;
  logic [31:0] dat_i = 32'h0;
  logic        ack_i = 1'b0;
  logic        err_i = 1'b0;
  logic        rty_i = 1'b0;
  logic        busy_o, done_o, fault_o, cyc_o, stb_o, we_o;
  logic [31:0] rdata_o, adr_o, dat_o;
  logic [3:0]  sel_o;

  int          checks = 0;
  int          fails = 0;
  logic [31:0] mem_w;
  vec_t        exp_q[$];

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .store_i(store_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o), .fault_o(fault_o),
    .rdata_o(rdata_o), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o),
    .sel_o(sel_o), .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i)
  );

  // Issue one request (called just after a negedge) and act as the responder until done_o.
  task automatic do_access(input vec_t v, output obs_t o);
    int waits;
    int rty;
    o = '{default: 0};
    mem_w = v.mem_init;
    waits = v.waits;
    rty = v.n_rty;
    req_i = 1'b1; store_i = v.store; funct3_i = v.f3; addr_i = v.addr; wdata_i = v.wdata;
    @(posedge clk); #1;
    req_i = 1'b0; store_i = 1'b0; funct3_i = 3'b000; addr_i = 32'h0; wdata_i = 32'h0;
    for (int c = 1; c <= BUDGET; c++) begin
      @(negedge clk);
      ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0; dat_i = 32'h0;
      if (stb_o !== cyc_o) o.stb_bad = 1'b1;
      if (c == 1) o.busy1 = busy_o;
      if (done_o === 1'b1) begin
        o.done = 1'b1; o.fault = fault_o; o.rdata = rdata_o; o.lat = c;
        break;
      end
      if (cyc_o === 1'b1) begin
        if (!o.cyc_seen) begin
          o.cyc_seen = 1'b1; o.adr = adr_o; o.sel = sel_o; o.dat = dat_o; o.we = we_o;
        end else if ({adr_o, sel_o, dat_o, we_o} !== {o.adr, o.sel, o.dat, o.we}) begin
          o.unstable = 1'b1;
        end
        if (waits > 0) begin
          waits--;
        end else if (rty > 0) begin
          rty_i = 1'b1; rty--;
        end else if (v.err) begin
          err_i = 1'b1;
        end else begin
          ack_i = 1'b1;
          dat_i = mem_w;
          if (we_o === 1'b1)
            for (int i = 0; i < 4; i++)
              if (sel_o[i]) mem_w[8*i +: 8] = dat_o[8*i +: 8];
        end
      end else if (o.cyc_seen) begin
        o.drops++;
      end
    end
    o.mem = mem_w;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({cyc_o, stb_o, we_o, busy_o, done_o, fault_o} !== 6'b000000) begin
      fails++; $display("FAIL reset_ctrl got %b exp 000000", {cyc_o, stb_o, we_o, busy_o, done_o, fault_o});
    end
    checks++;
    if ({adr_o, sel_o, dat_o, rdata_o} !== {32'h0, 4'h0, 32'h0, 32'h0}) begin
      fails++; $display("FAIL reset_data adr %h sel %b dat %h rdata %h exp all 0", adr_o, sel_o, dat_o, rdata_o);
    end
    rst_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({cyc_o, busy_o, done_o} !== 3'b000) begin
      fails++; $display("FAIL idle_no_req got %b exp 000", {cyc_o, busy_o, done_o});
    end
  endtask

  task automatic test_lanes();
    vec_t v[$];
    vec_t e;
    obs_t o;
    v.push_back('{"lb_b3", 1'b0, 3'b000, 32'h2000_0003, 32'h0, 32'h0302_0100, 0, 0, 1'b0,
                  1'b0, 32'h0000_0003, 1'b1, 2, 1'b1, 32'h2000_0000, 4'b1000, 32'h0, 0, 32'h0302_0100});
    v.push_back('{"lh_h1", 1'b0, 3'b001, 32'h2000_0002, 32'h0, 32'h8382_8180, 0, 0, 1'b0,
                  1'b0, 32'hFFFF_8382, 1'b1, 2, 1'b1, 32'h2000_0000, 4'b1100, 32'h0, 0, 32'h8382_8180});
    v.push_back('{"lhu_h1", 1'b0, 3'b101, 32'h2000_0002, 32'h0, 32'h8382_8180, 0, 0, 1'b0,
                  1'b0, 32'h0000_8382, 1'b1, 2, 1'b1, 32'h2000_0000, 4'b1100, 32'h0, 0, 32'h8382_8180});
    v.push_back('{"lb_b0", 1'b0, 3'b000, 32'h2000_0100, 32'h0, 32'h8382_8180, 0, 0, 1'b0,
                  1'b0, 32'hFFFF_FF80, 1'b1, 2, 1'b1, 32'h2000_0100, 4'b0001, 32'h0, 0, 32'h8382_8180});
    v.push_back('{"lbu_b1", 1'b0, 3'b100, 32'h2000_0101, 32'h0, 32'h8382_8180, 0, 0, 1'b0,
                  1'b0, 32'h0000_0081, 1'b1, 2, 1'b1, 32'h2000_0100, 4'b0010, 32'h0, 0, 32'h8382_8180});
    v.push_back('{"lw_wait3", 1'b0, 3'b010, 32'h2000_0004, 32'h0, 32'h1234_5678, 3, 0, 1'b0,
                  1'b0, 32'h1234_5678, 1'b1, 5, 1'b1, 32'h2000_0004, 4'b1111, 32'h0, 0, 32'h1234_5678});
    v.push_back('{"sh_h1", 1'b1, 3'b001, 32'h2000_0002, 32'hF3F2_F1F0, 32'hDEAD_BEEF, 0, 0, 1'b0,
                  1'b0, 32'h0, 1'b0, 2, 1'b1, 32'h2000_0000, 4'b1100, 32'hF1F0_F1F0, 0, 32'hF1F0_BEEF});
    v.push_back('{"sb_b1", 1'b1, 3'b000, 32'h2000_0001, 32'h0000_00A5, 32'hDEAD_BEEF, 0, 0, 1'b0,
                  1'b0, 32'h0, 1'b0, 2, 1'b1, 32'h2000_0000, 4'b0010, 32'hA5A5_A5A5, 0, 32'hDEAD_A5EF});
    v.push_back('{"sw_w", 1'b1, 3'b010, 32'h2000_0008, 32'hCAFE_F00D, 32'h0000_0000, 0, 0, 1'b0,
                  1'b0, 32'h0, 1'b0, 2, 1'b1, 32'h2000_0008, 4'b1111, 32'hCAFE_F00D, 0, 32'hCAFE_F00D});
    foreach (v[i]) begin
      exp_q.push_back(v[i]);
      do_access(v[i], o);
      e = exp_q.pop_front();
      checks++; if (!o.done) begin fails++; $display("FAIL %s timeout got no done_o exp done", e.name); end
      checks++; if (o.fault !== e.fault) begin fails++; $display("FAIL %s fault got %b exp %b", e.name, o.fault, e.fault); end
      checks++; if (o.lat != e.lat) begin fails++; $display("FAIL %s latency got %0d exp %0d", e.name, o.lat, e.lat); end
      if (e.chk_rdata) begin
        checks++; if (o.rdata !== e.rdata) begin fails++; $display("FAIL %s rdata got %h exp %h", e.name, o.rdata, e.rdata); end
      end
      checks++;
      if ({o.adr, o.sel, o.dat, o.we} !== {e.adr, e.sel, e.dat, e.store}) begin
        fails++; $display("FAIL %s bus adr %h sel %b dat %h we %b exp %h %b %h %b", e.name, o.adr, o.sel, o.dat, o.we, e.adr, e.sel, e.dat, e.store);
      end
      checks++; if (o.busy1 !== 1'b1) begin fails++; $display("FAIL %s busy got %b exp 1", e.name, o.busy1); end
      checks++; if (o.mem !== e.mem_after) begin fails++; $display("FAIL %s memory got %h exp %h", e.name, o.mem, e.mem_after); end
      checks++; if (o.stb_bad) begin fails++; $display("FAIL %s stb_cyc got mismatch exp equal", e.name); end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[$];
    vec_t e;
    obs_t o;
    v.push_back('{"b2b_lb", 1'b0, 3'b000, 32'h2000_0000, 32'h0, 32'h0000_00FF, 0, 0, 1'b0,
                  1'b0, 32'hFFFF_FFFF, 1'b1, 2, 1'b1, 32'h2000_0000, 4'b0001, 32'h0, 0, 32'h0000_00FF});
    v.push_back('{"b2b_lhu", 1'b0, 3'b101, 32'h2000_0000, 32'h0, 32'h0000_FFFF, 0, 0, 1'b0,
                  1'b0, 32'h0000_FFFF, 1'b1, 2, 1'b1, 32'h2000_0000, 4'b0011, 32'h0, 0, 32'h0000_FFFF});
    foreach (v[i]) begin
      exp_q.push_back(v[i]);
      do_access(v[i], o);
      e = exp_q.pop_front();
      checks++; if (o.lat != e.lat) begin fails++; $display("FAIL %s latency got %0d exp %0d", e.name, o.lat, e.lat); end
      checks++; if (o.rdata !== e.rdata) begin fails++; $display("FAIL %s rdata got %h exp %h", e.name, o.rdata, e.rdata); end
    end
  endtask

  task automatic test_retry_fault();
    vec_t v[$];
    vec_t e;
    obs_t o;
    v.push_back('{"rty2_ack", 1'b0, 3'b010, 32'h2000_0010, 32'h0, 32'h1122_3344, 0, 2, 1'b0,
                  1'b0, 32'h1122_3344, 1'b1, 6, 1'b1, 32'h2000_0010, 4'b1111, 32'h0, 2, 32'h1122_3344});
    v.push_back('{"rty4_fault", 1'b0, 3'b010, 32'h2000_0010, 32'h0, 32'h5566_7788, 0, 4, 1'b0,
                  1'b1, 32'h1122_3344, 1'b1, 8, 1'b1, 32'h2000_0010, 4'b1111, 32'h0, 3, 32'h5566_7788});
    v.push_back('{"sw_err", 1'b1, 3'b010, 32'h2000_0014, 32'h55AA_55AA, 32'h0, 0, 0, 1'b1,
                  1'b1, 32'h1122_3344, 1'b1, 2, 1'b1, 32'h2000_0014, 4'b1111, 32'h55AA_55AA, 0, 32'h0});
    v.push_back('{"illegal_f3", 1'b0, 3'b011, 32'h2000_0018, 32'h0, 32'h0, 0, 0, 1'b0,
                  1'b1, 32'h1122_3344, 1'b1, 1, 1'b0, 32'h0, 4'b0000, 32'h0, 0, 32'h0});
    v.push_back('{"store_lbu", 1'b1, 3'b100, 32'h2000_0018, 32'h0, 32'h0, 0, 0, 1'b0,
                  1'b1, 32'h1122_3344, 1'b1, 1, 1'b0, 32'h0, 4'b0000, 32'h0, 0, 32'h0});
`ifdef LSU_MISALIGNED_TRAP_EN
    v.push_back('{"lw_mis", 1'b0, 3'b010, 32'h2000_0002, 32'h0, 32'h8765_4321, 0, 0, 1'b0,
                  1'b1, 32'h1122_3344, 1'b1, 1, 1'b0, 32'h0, 4'b0000, 32'h0, 0, 32'h8765_4321});
`else
    v.push_back('{"lw_mis", 1'b0, 3'b010, 32'h2000_0002, 32'h0, 32'h8765_4321, 0, 0, 1'b0,
                  1'b0, 32'h8765_4321, 1'b1, 2, 1'b1, 32'h2000_0000, 4'b1111, 32'h0, 0, 32'h8765_4321});
`endif
    foreach (v[i]) begin
      exp_q.push_back(v[i]);
      do_access(v[i], o);
      e = exp_q.pop_front();
      checks++; if (!o.done) begin fails++; $display("FAIL %s timeout got no done_o exp done", e.name); end
      checks++; if (o.fault !== e.fault) begin fails++; $display("FAIL %s fault got %b exp %b", e.name, o.fault, e.fault); end
      checks++; if (o.lat != e.lat) begin fails++; $display("FAIL %s latency got %0d exp %0d", e.name, o.lat, e.lat); end
      checks++; if (o.rdata !== e.rdata) begin fails++; $display("FAIL %s rdata got %h exp %h", e.name, o.rdata, e.rdata); end
      checks++; if (o.cyc_seen != e.cyc) begin fails++; $display("FAIL %s cyc_seen got %b exp %b", e.name, o.cyc_seen, e.cyc); end
      checks++; if (o.drops != e.drops) begin fails++; $display("FAIL %s cyc_drops got %0d exp %0d", e.name, o.drops, e.drops); end
      checks++; if (o.unstable) begin fails++; $display("FAIL %s reissue got changed adr/sel/dat exp identical", e.name); end
      checks++; if (o.mem !== e.mem_after) begin fails++; $display("FAIL %s memory got %h exp %h", e.name, o.mem, e.mem_after); end
      if (e.cyc) begin
        checks++;
        if ({o.adr, o.sel} !== {e.adr, e.sel}) begin
          fails++; $display("FAIL %s bus adr %h sel %b exp %h %b", e.name, o.adr, o.sel, e.adr, e.sel);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    vec_t v;
    vec_t e;
    obs_t o;
    int   bad;
    req_i = 1'b1; store_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h2000_0020;
    @(posedge clk); #1;
    req_i = 1'b0; funct3_i = 3'b000; addr_i = 32'h0;
    repeat (3) @(negedge clk);
    checks++; if (cyc_o !== 1'b1) begin fails++; $display("FAIL rst_mid_waiting cyc got %b exp 1", cyc_o); end
    rst_i = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({cyc_o, stb_o, busy_o, done_o, rdata_o} !== {4'b0000, 32'h0}) begin
      fails++; $display("FAIL rst_mid_drop cyc %b stb %b busy %b done %b rdata %h exp 0", cyc_o, stb_o, busy_o, done_o, rdata_o);
    end
    @(negedge clk);
    rst_i = 1'b0;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done_o === 1'b1 || cyc_o === 1'b1) bad++;
    end
    checks++; if (bad != 0) begin fails++; $display("FAIL rst_mid_quiet got %0d active cycles exp 0", bad); end
    v = '{"lw_after_rst", 1'b0, 3'b010, 32'h2000_001C, 32'h0, 32'h0BAD_F00D, 0, 0, 1'b0,
          1'b0, 32'h0BAD_F00D, 1'b1, 2, 1'b1, 32'h2000_001C, 4'b1111, 32'h0, 0, 32'h0BAD_F00D};
    exp_q.push_back(v);
    do_access(v, o);
    e = exp_q.pop_front();
    checks++; if (o.lat != e.lat) begin fails++; $display("FAIL %s latency got %0d exp %0d", e.name, o.lat, e.lat); end
    checks++; if (o.rdata !== e.rdata) begin fails++; $display("FAIL %s rdata got %h exp %h", e.name, o.rdata, e.rdata); end
    checks++; if (o.fault !== e.fault) begin fails++; $display("FAIL %s fault got %b exp %b", e.name, o.fault, e.fault); end
  endtask

  initial begin
    test_reset();
    test_lanes();
    test_back_to_back();
    test_retry_fault();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
